ysyx_axi_spm: RTL
=================

# ysyx_axi_spm

AXI4 slave scratchpad memory (SPM) that answers the core's `io_slave_*` port, the responder end of the core's AXI4 interface. It accepts single and burst reads and writes from an external initiator (DMA, debug host, testbench) into a 32-bit-wide on-chip SRAM window. It sits outside the core beside the SoC crossbar and returns standard AXI4 responses. It serves one transaction at a time.

## Interface
- `XLEN`, 32, data and address width; only 32 is supported.
- `BASE_ADDR`, 32'h0f00_0000, byte address of the first SPM word.
- `DEPTH`, 4096, number of 32-bit words; must be a power of two.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `io_slave_ar{burst[2],size[3],len[8],id[4],addr[XLEN],valid}` in; `io_slave_arready` out 1: read-address channel.
- `io_slave_r{id[4],last,data[XLEN],resp[2],valid}` out; `io_slave_rready` in 1: read-data channel.
- `io_slave_aw{burst,size,len,id,addr,valid}` in, same widths as AR; `io_slave_awready` out 1: write-address channel.
- `io_slave_w{last,data[XLEN],strb[4],valid}` in; `io_slave_wready` out 1: write-data channel.
- `io_slave_b{id[4],resp[2],valid}` out; `io_slave_bready` in 1: write-response channel.

## Operation
- The FSM has five states: IDLE, RD_ISSUE, RD_DATA, WR_DATA and WR_RESP. Only one transaction is in flight at a time.
- A registered `alive` flag is 0 while `reset` is low. It goes to 1 on the first edge after release.
- In IDLE with `alive` set:
  - `arready` and `awready` are combinational grants.
  - When both `arvalid` and `awvalid` are high, the grant goes to the channel not served last (round-robin). The `last_was_write` flag resets to 1, so the first tie goes to read.
- Every handshake latches id, len, size and burst, plus a beat counter cleared to 0.
- The address checks assign a response code per transaction:
  - If any beat falls outside [BASE_ADDR, BASE_ADDR+4*DEPTH), the response is DECERR (2'b11).
  - If `burst`=WRAP (2'b10) or `size`>2, the response is SLVERR (2'b10).
  - Otherwise the response is OKAY (2'b00).
  - An error still returns the full number of beats. Errored reads return `rdata`=0. Errored writes leave the SRAM unmodified.
- Address stepping:
  - INCR adds `1<<size` per beat.
  - FIXED holds the address constant.
  - The SRAM word index is (addr-BASE_ADDR)>>2. Narrow beats return the whole word, and the initiator selects the lanes.
- Read path:
  - RD_ISSUE reads beat 0, then moves to RD_DATA.
  - RD_DATA presents `rvalid`, `rid` and `rresp`. `rlast` is high when beat==len.
  - On each `rvalid&&rready` the next beat's SRAM read issues in the same cycle, giving one beat per cycle.
  - The last handshake returns to IDLE.
  - While `rready` is low, `rdata` and the other R outputs hold stable.
- Write path:
  - In WR_DATA, `wready` is 1. Each W handshake writes the SRAM with a `wstrb` byte mask, if the response is OKAY.
  - When `wlast` is seen, the FSM moves to WR_RESP.
  - If `wlast` arrives at a beat other than len, `bresp` is SLVERR. Once len+1 beats have completed, further beats are still accepted without writing until `wlast`.
- WR_RESP holds `bvalid` with `bid` until `bready`, then returns to IDLE.
- Reset at any point:
  - All valids and readies fall immediately. Because readies are gated by `alive`, this is combinational.
  - The FSM returns to IDLE and the in-flight transaction is dropped.
  - SRAM contents are retained.

## Timing
- Every output resets to 0.
- Read latency: AR handshake in cycle T, SRAM read in T+1, first `rvalid` in T+2. A burst of N beats with `rready`=1 finishes at T+N+1.
- Write: AW handshake in T gives `wready` from T+1. The `wlast` handshake in cycle U gives `bvalid` in U+1. The next AR/AW grant comes at the earliest in the cycle after the B handshake.
- Valid/ready rules:
  - `rvalid` and `bvalid` never drop without a handshake.
  - `arready` and `awready` are never high at the same time.
  - W beats that arrive before the AW handshake wait, because `wready` is 0 in IDLE.

## Structure
- Shared package `ysyx_axi_pkg` holds:
  - AXI constants: BURST_FIXED/INCR/WRAP and RESP_OKAY/SLVERR/DECERR.
  - The FSM state enum.
  - A `axi_req_t` struct for the latched {id,len,size,burst,addr,resp}.
- Sub-module `ysyx_spm_ram` is a 1RW synchronous SRAM with a 4-bit byte write mask. Its read data holds while the read enable is low.

## Test plan
- Single read: write 0xDEADBEEF to 0x0f00_0010, then AR addr=0x0f00_0010 len=0 → `rvalid` at T+2 with `rdata`=0xDEADBEEF, `rlast`=1, `rresp`=0, `rid`=AR id.
- Burst: INCR write of len=3 at 0x0f00_0000 with data 1..4 and strb=4'hF → `bresp`=OKAY. INCR read len=3 with `rready` toggling every other cycle → data 1,2,3,4 in order, `rlast` only on the fourth beat, outputs stable while stalled.
- Byte strobe: write 0x11223344 strb=4'b0101 over 0xFFFFFFFF → read back 0xFF22FF44.
- Errors:
  - Read at 0x1000_0000 → `rresp`=DECERR, `rdata`=0.
  - WRAP burst → SLVERR.
  - Write len=3 with `wlast` on beat 1 → `bresp`=SLVERR.
- Arbitration and reset:
  - `arvalid` and `awvalid` asserted in the same cycle → read granted first, write next.
  - `reset` pulled low mid-burst → all outputs 0 immediately; after release, previously written data is intact.

Source files
------------

// File: rtl/ysyx_axi_pkg.sv
// Shared AXI4 definitions for the scratchpad slave.
//   - burst / response encodings
//   - FSM state enum of the SPM controller
//   - axi_req_t: attributes of the one transaction in flight
//   - next_beat_addr(): per-beat address step for FIXED / INCR bursts
package ysyx_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_DATA  = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_RESP  = 3'd4
  } spm_state_e;

  typedef struct packed {
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] addr;
    logic [1:0]  resp;
  } axi_req_t;

  // FIXED keeps the address; every other burst advances by the beat size.
  // Errored bursts (WRAP, reserved) never touch the SRAM, so their exact
  // stepping does not matter.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                 input logic [2:0]  size,
                                                 input logic [1:0]  burst);
    if (burst == BURST_FIXED) return addr;
    return addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/ysyx_axi_spm_if.sv
// AXI4 bus bundle between an initiator (master) and the SPM (slave).
// Channels: AR, R, AW, W, B with the io_slave_* field set of the core.
interface ysyx_axi_spm_if #(
  parameter int XLEN = 32
);
  logic            arvalid, arready;
  logic [XLEN-1:0] araddr;
  logic [3:0]      arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;

  logic            rvalid, rready, rlast;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic [3:0]      rid;

  logic            awvalid, awready;
  logic [XLEN-1:0] awaddr;
  logic [3:0]      awid;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;

  logic            wvalid, wready, wlast;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;

  logic            bvalid, bready;
  logic [1:0]      bresp;
  logic [3:0]      bid;

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );
endinterface

// File: rtl/ysyx_spm_ram.sv
// 1RW synchronous SRAM, 32-bit words with a per-byte write mask.
// Ports: clock; en (access enable); we (1 = write); wmask (byte lanes);
//        idx (word index); wdata; rdata (registered, holds while not read).
module ysyx_spm_ram #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       wmask,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end
endmodule

// File: rtl/ysyx_axi_spm.sv
// AXI4 slave scratchpad memory, one transaction at a time.
// Ports: clock; reset (async, active-low); io_slave (AXI4 slave modport)
// Serves single/burst FIXED and INCR reads and writes into a DEPTH x 32-bit
// SRAM mapped at BASE_ADDR. Out-of-window beats answer DECERR, WRAP /
// reserved bursts and sizes above 4 bytes answer SLVERR; errored bursts
// still run all beats but read zero and write nothing.
module ysyx_axi_spm
  import ysyx_axi_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0f00_0000,
  parameter int          DEPTH     = 4096
) (
  input logic            clock,
  input logic            reset,
  ysyx_axi_spm_if.slave  io_slave
);
  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  // Response for a whole burst, decided once at the address handshake.
  // Only INCR moves the address, so its last beat bounds the window check.
  function automatic logic [1:0] check_req(input logic [31:0] addr,
                                           input logic [7:0]  len,
                                           input logic [2:0]  size,
                                           input logic [1:0]  burst);
    logic [32:0] last_addr;
    last_addr = {1'b0, addr};
    if (burst == BURST_INCR) last_addr = {1'b0, addr} + ({25'd0, len} << size);
    if ({1'b0, addr} < {1'b0, BASE_ADDR} || last_addr >= END_ADDR) return RESP_DECERR;
    if (burst == BURST_WRAP || burst == 2'b11 || size > 3'd2) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  spm_state_e       state_q;
  axi_req_t         req_q;
  logic [8:0]       beat_q;
  logic             alive_q;
  logic             last_was_write_q;

  logic             in_idle, ar_win;
  logic             ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic             beat_last, beat_in_len;
  logic [XLEN-1:0]  next_addr, ram_addr, ram_off;
  logic [IDX_W-1:0] ram_idx;
  logic             ram_en, ram_we;
  logic [31:0]      ram_rdata;

  // Readies are gated by alive_q so they fall combinationally with reset.
  assign in_idle = alive_q && (state_q == ST_IDLE);
  assign ar_win  = io_slave.arvalid && (!io_slave.awvalid || last_was_write_q);

  assign io_slave.arready = in_idle && ar_win;
  assign io_slave.awready = in_idle && io_slave.awvalid && !ar_win;
  assign io_slave.wready  = (state_q == ST_WR_DATA);
  assign io_slave.rvalid  = (state_q == ST_RD_DATA);
  assign io_slave.bvalid  = (state_q == ST_WR_RESP);

  assign ar_hs = io_slave.arvalid && io_slave.arready;
  assign aw_hs = io_slave.awvalid && io_slave.awready;
  assign r_hs  = io_slave.rvalid  && io_slave.rready;
  assign w_hs  = io_slave.wvalid  && io_slave.wready;
  assign b_hs  = io_slave.bvalid  && io_slave.bready;

  // beat_q saturates at len+1 so surplus write beats stop advancing it.
  assign beat_last   = (beat_q == {1'b0, req_q.len});
  assign beat_in_len = (beat_q <= {1'b0, req_q.len});
  assign next_addr   = next_beat_addr(req_q.addr, req_q.size, req_q.burst);

  assign io_slave.rid   = io_slave.rvalid ? req_q.id   : 4'd0;
  assign io_slave.rresp = io_slave.rvalid ? req_q.resp : 2'd0;
  assign io_slave.rlast = io_slave.rvalid && beat_last;
  assign io_slave.rdata = (io_slave.rvalid && req_q.resp == RESP_OKAY) ? ram_rdata : '0;
  assign io_slave.bid   = io_slave.bvalid ? req_q.id   : 4'd0;
  assign io_slave.bresp = io_slave.bvalid ? req_q.resp : 2'd0;

  // In RD_DATA the SRAM prefetches the following beat on each R handshake.
  assign ram_we   = w_hs && beat_in_len && (req_q.resp == RESP_OKAY);
  assign ram_en   = (state_q == ST_RD_ISSUE) || (r_hs && !beat_last) || ram_we;
  assign ram_addr = (state_q == ST_RD_DATA) ? next_addr : req_q.addr;
  assign ram_off  = ram_addr - BASE_ADDR;
  assign ram_idx  = IDX_W'(ram_off >> 2);

  ysyx_spm_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .wmask (io_slave.wstrb),
    .idx   (ram_idx),
    .wdata (io_slave.wdata),
    .rdata (ram_rdata)
  );

  // Control: FSM, alive flag, round-robin history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      alive_q          <= 1'b0;
      last_was_write_q <= 1'b1;
    end else begin
      alive_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (ar_hs) begin
            state_q          <= ST_RD_ISSUE;
            last_was_write_q <= 1'b0;
          end else if (aw_hs) begin
            state_q          <= ST_WR_DATA;
            last_was_write_q <= 1'b1;
          end
        end
        ST_RD_ISSUE: state_q <= ST_RD_DATA;
        ST_RD_DATA:  if (r_hs && beat_last) state_q <= ST_IDLE;
        ST_WR_DATA:  if (w_hs && io_slave.wlast) state_q <= ST_WR_RESP;
        ST_WR_RESP:  if (b_hs) state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  // Transaction attributes and beat tracking
  always_ff @(posedge clock) begin
    if (ar_hs) begin
      req_q <= '{id: io_slave.arid, len: io_slave.arlen, size: io_slave.arsize,
                 burst: io_slave.arburst, addr: io_slave.araddr,
                 resp: check_req(io_slave.araddr, io_slave.arlen,
                                 io_slave.arsize, io_slave.arburst)};
      beat_q <= '0;
    end else if (aw_hs) begin
      req_q <= '{id: io_slave.awid, len: io_slave.awlen, size: io_slave.awsize,
                 burst: io_slave.awburst, addr: io_slave.awaddr,
                 resp: check_req(io_slave.awaddr, io_slave.awlen,
                                 io_slave.awsize, io_slave.awburst)};
      beat_q <= '0;
    end else if (r_hs && !beat_last) begin
      req_q.addr <= next_addr;
      beat_q     <= beat_q + 9'd1;
    end else if (w_hs) begin
      if (beat_in_len) begin
        req_q.addr <= next_addr;
        beat_q     <= beat_q + 9'd1;
      end
      if (io_slave.wlast && !beat_last && req_q.resp == RESP_OKAY)
        req_q.resp <= RESP_SLVERR;
    end
  end

endmodule
